// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   BUS_COMMAND : command encoding on the cache/memory buses
//   OWNER_T     : which cache owns an outstanding memory tag
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        OWN_NONE = 2'h0,
        OWN_I    = 2'h1,
        OWN_D    = 2'h2
    } OWNER_T;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tag owner table: one OWNER_T entry per memory tag.
//   clock, reset       : posedge clock, async active-low reset (all entries OWN_NONE)
//   wr_en/wr_tag/wr_owner : record owner of a newly accepted load tag
//   clr_en/clr_tag     : release a tag whose data has returned
//   rd_tag/rd_owner    : combinational lookup (pre-edge contents)
// A write and a clear to the same tag in one cycle: the write wins.
module mem_tag_owner_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TAG_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  OWNER_T              wr_owner,
    input  logic                clr_en,
    input  logic [TAG_BITS-1:0] clr_tag,
    input  logic [TAG_BITS-1:0] rd_tag,
    output OWNER_T              rd_owner
);

    localparam int unsigned Depth = 2 ** TAG_BITS;

    OWNER_T owner_q [Depth];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                owner_q[i] <= OWN_NONE;
            end
        end else begin
            if (clr_en) begin
                owner_q[clr_tag] <= OWN_NONE;
            end
            // Ordered after the clear so a same-cycle reissue keeps the new owner.
            if (wr_en) begin
                owner_q[wr_tag] <= wr_owner;
            end
        end
    end

    assign rd_owner = owner_q[rd_tag];

    // Memory handed out a tag that is still outstanding (and not being released now).
    always @(posedge clock) begin
        if (reset && wr_en && !(clr_en && clr_tag == wr_tag)) begin
            assert (owner_q[wr_tag] == OWN_NONE)
            else $error("owner table: tag %0d reissued while still owned", wr_tag);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the icache and dcache onto the single main-memory port and routes
// returning load data back to the cache that issued the load.
//   clock, reset                  : posedge clock, async active-low reset
//   Icache2mem_command/addr       : icache request (loads only)
//   Dcache2mem_command/addr/data  : dcache request (loads and stores)
//   mem2proc_response             : memory accept tag for this cycle, 0 = rejected
//   mem2proc_data/tag             : returning load data and its tag, tag 0 = none
//   proc2mem_command/addr/data    : forwarded winning request
//   Imem2proc_response/data/tag   : icache view of memory
//   Dmem2proc_response/data/tag   : dcache view of memory
// Request path is purely combinational; the only state is the starvation counter
// and the tag owner table.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TAG_BITS     = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          Icache2mem_command,
    input  logic [63:0]         Icache2mem_addr,
    input  logic [1:0]          Dcache2mem_command,
    input  logic [63:0]         Dcache2mem_addr,
    input  logic [63:0]         Dcache2mem_data,
    input  logic [TAG_BITS-1:0] mem2proc_response,
    input  logic [63:0]         mem2proc_data,
    input  logic [TAG_BITS-1:0] mem2proc_tag,
    output logic [1:0]          proc2mem_command,
    output logic [63:0]         proc2mem_addr,
    output logic [63:0]         proc2mem_data,
    output logic [TAG_BITS-1:0] Imem2proc_response,
    output logic [63:0]         Imem2proc_data,
    output logic [TAG_BITS-1:0] Imem2proc_tag,
    output logic [TAG_BITS-1:0] Dmem2proc_response,
    output logic [63:0]         Dmem2proc_data,
    output logic [TAG_BITS-1:0] Dmem2proc_tag
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    logic [StarveW-1:0] starve_q, starve_d;
    logic               i_req, d_req, grant_i, grant_d, accepted;
    logic               load_granted, tbl_wr_en, tbl_clr_en;
    OWNER_T             tbl_wr_owner, tbl_rd_owner;

    always_comb begin
        // Holding everything idle while reset is low also suppresses table writes.
        i_req   = reset && (Icache2mem_command != BUS_NONE);
        d_req   = reset && (Dcache2mem_command != BUS_NONE);
        grant_i = i_req && (!d_req || starve_q == StarveMax);
        grant_d = d_req && !grant_i;
        accepted = mem2proc_response != '0;

        proc2mem_command   = BUS_NONE;
        proc2mem_addr      = '0;
        proc2mem_data      = '0;
        Imem2proc_response = '0;
        Dmem2proc_response = '0;
        load_granted       = 1'b0;

        if (grant_i) begin
            proc2mem_command   = Icache2mem_command;
            proc2mem_addr      = Icache2mem_addr;
            Imem2proc_response = mem2proc_response;
            load_granted       = Icache2mem_command == BUS_LOAD;
        end else if (grant_d) begin
            proc2mem_command   = Dcache2mem_command;
            proc2mem_addr      = Dcache2mem_addr;
            Dmem2proc_response = mem2proc_response;
            load_granted       = Dcache2mem_command == BUS_LOAD;
            if (Dcache2mem_command == BUS_STORE) begin
                proc2mem_data = Dcache2mem_data;
            end
        end

        tbl_wr_en    = load_granted && accepted;
        tbl_wr_owner = grant_i ? OWN_I : OWN_D;
        tbl_clr_en   = reset && (mem2proc_tag != '0);

        // Any cycle icache wants the bus and does not get accepted counts as a loss.
        if (i_req && !(grant_i && accepted)) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
        end else begin
            starve_d = '0;
        end

        Imem2proc_tag = (tbl_clr_en && tbl_rd_owner == OWN_I) ? mem2proc_tag : '0;
        Dmem2proc_tag = (tbl_clr_en && tbl_rd_owner == OWN_D) ? mem2proc_tag : '0;
    end

    assign Imem2proc_data = mem2proc_data;
    assign Dmem2proc_data = mem2proc_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    mem_tag_owner_table #(
        .TAG_BITS (TAG_BITS)
    ) u_owner_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (tbl_wr_en),
        .wr_tag   (mem2proc_response),
        .wr_owner (tbl_wr_owner),
        .clr_en   (tbl_clr_en),
        .clr_tag  (mem2proc_tag),
        .rd_tag   (mem2proc_tag),
        .rd_owner (tbl_rd_owner)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Icache2mem_command, Dcache2mem_command, proc2mem_command;
    logic [63:0] Icache2mem_addr, Dcache2mem_addr, Dcache2mem_data;
    logic [3:0]  mem2proc_response, mem2proc_tag;
    logic [63:0] mem2proc_data, proc2mem_addr, proc2mem_data;
    logic [3:0]  Imem2proc_response, Imem2proc_tag, Dmem2proc_response, Dmem2proc_tag;
    logic [63:0] Imem2proc_data, Dmem2proc_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    mem_bus_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .Icache2mem_command (Icache2mem_command),
        .Icache2mem_addr    (Icache2mem_addr),
        .Dcache2mem_command (Dcache2mem_command),
        .Dcache2mem_addr    (Dcache2mem_addr),
        .Dcache2mem_data    (Dcache2mem_data),
        .mem2proc_response  (mem2proc_response),
        .mem2proc_data      (mem2proc_data),
        .mem2proc_tag       (mem2proc_tag),
        .proc2mem_command   (proc2mem_command),
        .proc2mem_addr      (proc2mem_addr),
        .proc2mem_data      (proc2mem_data),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag)
    );

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic [1:0] icmd, input logic [63:0] iaddr,
                         input logic [1:0] dcmd, input logic [63:0] daddr,
                         input logic [63:0] ddata, input logic [3:0] resp,
                         input logic [3:0] mtag, input logic [63:0] mdata);
        Icache2mem_command = icmd;
        Icache2mem_addr    = iaddr;
        Dcache2mem_command = dcmd;
        Dcache2mem_addr    = daddr;
        Dcache2mem_data    = ddata;
        mem2proc_response  = resp;
        mem2proc_tag       = mtag;
        mem2proc_data      = mdata;
    endtask

    // Push expectations, sample 1ns after the negedge drive, then cross the posedge.
    task automatic step(input string name, input logic [1:0] cmd, input logic [63:0] addr,
                        input logic [63:0] data, input logic [3:0] ir, input logic [3:0] dr,
                        input logic [3:0] it, input logic [3:0] dt);
        push({name, ".cmd"}, 64'(cmd));
        push({name, ".addr"}, addr);
        push({name, ".data"}, data);
        push({name, ".iresp"}, 64'(ir));
        push({name, ".dresp"}, 64'(dr));
        push({name, ".itag"}, 64'(it));
        push({name, ".dtag"}, 64'(dt));
        push({name, ".idata"}, mem2proc_data);
        push({name, ".ddata"}, mem2proc_data);
        #1;
        pop_check(64'(proc2mem_command));
        pop_check(proc2mem_addr);
        pop_check(proc2mem_data);
        pop_check(64'(Imem2proc_response));
        pop_check(64'(Dmem2proc_response));
        pop_check(64'(Imem2proc_tag));
        pop_check(64'(Dmem2proc_tag));
        pop_check(Imem2proc_data);
        pop_check(Dmem2proc_data);
        @(negedge clock);
    endtask

    initial begin
        logic [3:0] ret_tags [9] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd4, 4'd9, 4'd10, 4'd11, 4'd5};
        logic       ret_is_i [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_i, exp_d;

        drive(BUS_LOAD, 64'h100, BUS_NONE, 64'h0, 64'h0, 4'd3, 4'd0, 64'h0);
        @(negedge clock);
        step("rst_held", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;

        // Lone icache load, then its return and a stale repeat.
        drive(BUS_LOAD, 64'h100, BUS_NONE, 64'h0, 64'h0, 4'd3, 4'd0, 64'h0);
        step("t1_req", BUS_LOAD, 64'h100, 64'h0, 4'd3, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD);
        step("t1_ret", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd3, 4'd0);
        step("t1_reret", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Contention: dcache wins three times, then starved icache gets one grant.
        for (int k = 1; k <= 3; k++) begin
            drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'(k), 4'd0, 64'h0);
            step($sformatf("t2_d%0d", k), BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'(k), 4'd0, 4'd0);
        end
        drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd4, 4'd0, 64'h0);
        step("t2_i", BUS_LOAD, 64'h200, 64'h0, 4'd4, 4'd0, 4'd0, 4'd0);
        drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd6, 4'd0, 64'h0);
        step("t2_d_again", BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd6, 4'd0, 4'd0);

        // Store is forwarded with data but never recorded as an owner.
        drive(BUS_NONE, 64'h0, BUS_STORE, 64'h500, 64'hCAFE, 4'd5, 4'd0, 64'h0);
        step("t3_st", BUS_STORE, 64'h500, 64'hCAFE, 4'd0, 4'd5, 4'd0, 4'd0);

        // Same-cycle return of tag 7 (dcache) and reissue of tag 7 to icache.
        drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h700, 64'h0, 4'd7, 4'd0, 64'h0);
        step("t4_d", BUS_LOAD, 64'h700, 64'h0, 4'd0, 4'd7, 4'd0, 4'd0);
        drive(BUS_LOAD, 64'h170, BUS_NONE, 64'h0, 64'h0, 4'd7, 4'd7, 64'hBEEF);
        step("t4_swap", BUS_LOAD, 64'h170, 64'h0, 4'd7, 4'd0, 4'd0, 4'd7);
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'hF00D);
        step("t4_ret", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd7, 4'd0);

        // Rejections count as icache losses, whether icache lost or was granted.
        for (int k = 0; k < 3; k++) begin
            drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
            step("t5_rej_d", BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        end
        drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd9, 4'd0, 64'h0);
        step("t5_i_prio", BUS_LOAD, 64'h200, 64'h0, 4'd9, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            drive(BUS_LOAD, 64'h200, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
            step("t5_rej_i", BUS_LOAD, 64'h200, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        end
        drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd10, 4'd0, 64'h0);
        step("t5_i_prio2", BUS_LOAD, 64'h200, 64'h0, 4'd10, 4'd0, 4'd0, 4'd0);
        drive(BUS_LOAD, 64'h200, BUS_LOAD, 64'h300, 64'h0, 4'd11, 4'd0, 64'h0);
        step("t5_d_after", BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd11, 4'd0, 4'd0);

        // Drain every outstanding tag; tag 5 was a store so nobody gets it.
        for (int k = 0; k < 9; k++) begin
            exp_i = ret_is_i[k] ? ret_tags[k] : 4'd0;
            exp_d = (!ret_is_i[k] && ret_tags[k] != 4'd5) ? ret_tags[k] : 4'd0;
            drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, ret_tags[k],
                  64'h1000 + 64'(ret_tags[k]));
            step($sformatf("ret_tag%0d", ret_tags[k]), BUS_NONE, 64'h0, 64'h0,
                 4'd0, 4'd0, exp_i, exp_d);
        end

        // Reset with tags 2 (icache) and 4 (dcache) outstanding.
        drive(BUS_LOAD, 64'h220, BUS_NONE, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
        step("t6_i", BUS_LOAD, 64'h220, 64'h0, 4'd2, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h440, 64'h0, 4'd4, 4'd0, 64'h0);
        step("t6_d", BUS_LOAD, 64'h440, 64'h0, 4'd0, 4'd4, 4'd0, 4'd0);
        reset = 1'b0;
        drive(BUS_LOAD, 64'h220, BUS_LOAD, 64'h440, 64'h0, 4'd8, 4'd2, 64'h55);
        step("t6_in_rst", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        reset = 1'b1;
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd2, 64'h66);
        step("t6_ret2", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd4, 64'h77);
        step("t6_ret4", BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
